// File: rtl/root_result_packer.sv
// root_result_packer
// Buffers Q10.10 root results as rounded (or truncated) Q10.6 words in a
// small circular FIFO and serializes each word as two bytes, high byte first,
// over a valid/ready byte interface.
module root_result_packer #(
    parameter int DEPTH    = 4,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [19:0]                in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // Serializer states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HI   = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;

    // Storage and state
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          overflow_reg;
    logic [1:0]    state_reg;
    logic [1:0]    state_next;
    logic [15:0]   hold_reg;

    // Datapath helpers
    logic          round_bit;
    logic [16:0]   conv_sum;
    logic [15:0]   conv_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          handshake;
    logic          pop;
    logic          push;

    // Rounding contributes bit 3 (half an LSB of Q10.6) only when enabled
    generate
        if (ROUND_EN) begin : g_round
            assign round_bit = in_data[3];
        end else begin : g_trunc
            assign round_bit = 1'b0;
        end
    endgenerate

    // Q10.10 -> Q10.6 with saturation when rounding carries out of 16 bits
    always_comb begin
        conv_sum = {1'b0, in_data[19:4]} + {16'd0, round_bit};
        conv_q   = conv_sum[16] ? 16'hFFFF : conv_sum[15:0];
    end

    // Pop when idle with data waiting, or when the low byte completes and
    // more data is queued (back-to-back pairs without an idle bubble).
    // A push into a full FIFO is only accepted if a pop frees a slot.
    always_comb begin
        fifo_full  = (count_reg == COUNT_FULL);
        fifo_empty = (count_reg == '0);
        handshake  = out_valid && out_ready;
        pop        = !fifo_empty &&
                     ((state_reg == ST_IDLE) ||
                      ((state_reg == ST_LO) && handshake));
        push       = in_valid && (!fifo_full || pop);
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    // Serializer next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (pop) state_next = ST_HI;
            ST_HI:   if (handshake) state_next = ST_LO;
            ST_LO:   if (handshake) state_next = pop ? ST_HI : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Buffer RAM write port; no reset so it maps onto block/distributed RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= conv_q;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            if (in_valid && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Registered RAM read into the hold register; a same-cycle write to the
    // head slot (full FIFO, push and pop together) returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= 16'h0000;
        end else if (pop) begin
            hold_reg <= mem[rd_ptr_reg];
        end
    end

    // Serializer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output byte selection; zero whenever nothing is offered
    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_reg)
            ST_HI: begin
                out_valid = 1'b1;
                out_data  = hold_reg[15:8];
            end
            ST_LO: begin
                out_valid = 1'b1;
                out_data  = hold_reg[7:0];
            end
            default: begin
                out_valid = 1'b0;
                out_data  = 8'h00;
            end
        endcase
    end

    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_root_result_packer.sv
// Testbench for root_result_packer: directed scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_root_result_packer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        t_out_valid;
    logic [7:0]  t_out_data;
    logic [2:0]  t_fifo_count;
    logic        t_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int q_raw[$];
    bit m_holding;
    bit m_lo;
    int m_hold_raw;
    bit m_ovf;

    root_result_packer #(.DEPTH(DEPTH), .ROUND_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    root_result_packer #(.DEPTH(DEPTH), .ROUND_EN(1'b0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(t_out_valid), .out_data(t_out_data),
        .fifo_count(t_fifo_count), .overflow(t_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Q10.10 -> Q10.6 by plain arithmetic
    function automatic int conv(input int d, input bit rnd);
        int v;
        v = (d >> 4) + (rnd ? ((d >> 3) & 1) : 0);
        if (v > 65535) v = 65535;
        return v;
    endfunction

    function automatic int exp_byte(input bit rnd);
        int v;
        if (!m_holding) return 0;
        v = conv(m_hold_raw, rnd);
        return m_lo ? (v & 255) : ((v >> 8) & 255);
    endfunction

    task automatic model_clear();
        q_raw.delete();
        m_holding  = 1'b0;
        m_lo       = 1'b0;
        m_hold_raw = 0;
        m_ovf      = 1'b0;
    endtask

    task automatic check_outputs();
        check_eq("out_valid", int'(out_valid), int'(m_holding));
        check_eq("out_data", int'(out_data), exp_byte(1'b1));
        check_eq("fifo_count", int'(fifo_count), q_raw.size());
        check_eq("overflow", int'(overflow), int'(m_ovf));
        check_eq("trunc_out_valid", int'(t_out_valid), int'(m_holding));
        check_eq("trunc_out_data", int'(t_out_data), exp_byte(1'b0));
        check_eq("trunc_fifo_count", int'(t_fifo_count), q_raw.size());
    endtask

    // Advance the model by one clock edge with the given inputs
    task automatic model_step(input bit v, input int d, input bit r);
        bit hs;
        bit pop;
        bit acc;
        int n;
        n   = q_raw.size();
        hs  = m_holding && r;
        pop = (n > 0) && (!m_holding || (hs && m_lo));
        acc = 1'b0;
        if (v) begin
            if (n < DEPTH || pop) acc = 1'b1;
            else m_ovf = 1'b1;
        end
        if (!m_holding) begin
            if (pop) begin m_holding = 1'b1; m_lo = 1'b0; end
        end else if (hs) begin
            if (!m_lo) m_lo = 1'b1;
            else if (pop) m_lo = 1'b0;
            else begin m_holding = 1'b0; m_lo = 1'b0; end
        end
        if (pop) m_hold_raw = q_raw.pop_front();
        if (acc) q_raw.push_back(d);
    endtask

    // One cycle: check at the negedge, drive inputs, step model, wait
    task automatic cycle(input bit v, input int d, input bit r);
        check_outputs();
        in_valid  = v;
        in_data   = d[19:0];
        out_ready = r;
        model_step(v, d, r);
        @(negedge clk);
        $display("cyc t=%0t in_valid=%0b in_data=%05h out_ready=%0b -> out_valid=%0b out_data=%02h count=%0d ovf=%0b",
                 $time, v, d[19:0], r, out_valid, out_data, fifo_count, overflow);
    endtask

    // Asynchronous reset pulse from mid-cycle, released before a rising edge
    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_out_data", int'(out_data), 0);
        check_eq("rst_fifo_count", int'(fifo_count), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released at t=%0t", $time);
    endtask

    initial begin
        int d;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Single result, ready high: bytes 00, C0 then idle
        cycle(1, 20'h00C00, 1);
        repeat (4) cycle(0, 0, 1);
        // Rounding boundary and saturation
        cycle(1, 20'h00008, 1);
        repeat (4) cycle(0, 0, 1);
        cycle(1, 20'hFFFF8, 1);
        repeat (4) cycle(0, 0, 1);
        // Back-to-back strobes: four contiguous bytes
        cycle(1, 20'h12345, 1);
        cycle(1, 20'h6789A, 1);
        repeat (6) cycle(0, 0, 1);

        // Six strobes while stalled: FIFO fills and one result is dropped
        repeat (6) cycle(1, 20'h00400, 0);
        check_eq("full_count", int'(fifo_count), DEPTH);
        check_eq("full_overflow", int'(overflow), 1);
        repeat (14) cycle(0, 0, 1);
        check_eq("drained_count", int'(fifo_count), 0);
        check_eq("overflow_sticky", int'(overflow), 1);

        // Full with simultaneous pop: push accepted, count holds
        do_reset();
        repeat (5) cycle(1, 20'h0ABC0, 0);
        cycle(0, 0, 1);
        cycle(1, 20'h0DEF0, 1);
        repeat (14) cycle(0, 0, 1);

        // Reset while in the low byte with two entries buffered
        do_reset();
        repeat (3) cycle(1, 20'h00400, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        check_eq("lo_state_valid", int'(out_valid), 1);
        check_eq("lo_state_count", int'(fifo_count), 2);
        do_reset();
        repeat (5) cycle(0, 0, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0: d = 20'hFFFF8;
                1: d = int'($urandom_range(0, 15));
                default: d = int'($urandom & 32'hFFFFF);
            endcase
            cycle(($urandom_range(0, 99) < 40), d,
                  ($urandom_range(0, 99) < ((i / 500) % 2 ? 30 : 75)));
            if (i % 1000 == 999) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
